// File: rtl/crc24_check.sv
// ============================================================================
// Module      : crc24_check
// Description : Byte-serial CRC24 checker; payload followed by 3 CRC bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc24_check #(
  parameter logic [23:0] POLY = 24'h800063,
  parameter logic [23:0] INIT = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        res_valid,
  output logic        pass,
  output logic        len_err,
  output logic [23:0] crc_calc,
  output logic [23:0] crc_rx,
  output logic [15:0] blk_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [23:0] r_crc;
  logic [7:0]  r_dl0;
  logic [7:0]  r_dl1;
  logic [7:0]  r_dl2;
  logic [15:0] r_cnt;
  logic        r_res_valid;
  logic        r_pass;
  logic        r_len_err;
  logic [23:0] r_crc_calc;
  logic [23:0] r_crc_rx;
  logic [15:0] r_blk_len;

  logic        w_accept;
  logic        w_full;
  logic        w_short;
  logic [15:0] w_len;
  logic [23:0] w_crc_fold;
  logic [23:0] w_crc_next;
  logic [23:0] w_rx;

  // Eight MSB-first shift steps of the LFSR, unrolled into one cycle.
  function automatic logic [23:0] crc_byte(input logic [23:0] crc, input logic [7:0] d);
    logic [23:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[23] ^ d[i]) c = {c[22:0], 1'b0} ^ POLY;
      else              c = {c[22:0], 1'b0};
    end
    return c;
  endfunction

  assign s_ready    = (r_state != DONE);
  assign w_accept   = s_valid & s_ready;
  assign w_full     = (r_cnt >= 16'd3);
  assign w_short    = (r_cnt < 16'd3);
  assign w_len      = (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1;
  assign w_crc_fold = crc_byte(r_crc, r_dl2);
  assign w_crc_next = w_full ? w_crc_fold : r_crc;
  assign w_rx       = {r_dl1, r_dl0, s_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_dl0       <= 8'h00;
      r_dl1       <= 8'h00;
      r_dl2       <= 8'h00;
      r_cnt       <= 16'd0;
      r_res_valid <= 1'b0;
      r_pass      <= 1'b0;
      r_len_err   <= 1'b0;
      r_crc_calc  <= 24'd0;
      r_crc_rx    <= 24'd0;
      r_blk_len   <= 16'd0;
    end else if (abort) begin
      // Discard the partial block; last result fields stay visible.
      r_state     <= IDLE;
      r_crc       <= INIT;
      r_dl0       <= 8'h00;
      r_dl1       <= 8'h00;
      r_dl2       <= 8'h00;
      r_cnt       <= 16'd0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            if (s_last) begin
              r_state     <= DONE;
              r_res_valid <= 1'b1;
              r_blk_len   <= w_len;
              r_len_err   <= w_short;
              r_crc_calc  <= w_short ? 24'd0 : w_crc_next;
              r_crc_rx    <= w_short ? 24'd0 : w_rx;
              r_pass      <= !w_short && (w_crc_next == w_rx);
            end else begin
              r_state <= RUN;
              r_dl0   <= s_data;
              r_dl1   <= r_dl0;
              r_dl2   <= r_dl1;
              r_cnt   <= w_len;
              r_crc   <= w_crc_next;
            end
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_crc       <= INIT;
          r_dl0       <= 8'h00;
          r_dl1       <= 8'h00;
          r_dl2       <= 8'h00;
          r_cnt       <= 16'd0;
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign pass      = r_pass;
  assign len_err   = r_len_err;
  assign crc_calc  = r_crc_calc;
  assign crc_rx    = r_crc_rx;
  assign blk_len   = r_blk_len;

endmodule

`default_nettype wire

// File: tb/tb_crc24_check.sv
// ============================================================================
// Module      : tb_crc24_check
// Description : Directed self-checking bench for crc24_check (CRC24B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc24_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        res_valid;
  logic        pass;
  logic        len_err;
  logic [23:0] crc_calc;
  logic [23:0] crc_rx;
  logic [15:0] blk_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int pulses = 0;
  int bad_ready = 0;
  bit gaps = 1'b0;

  crc24_check #(.POLY(24'h800063), .INIT(24'h000000)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .res_valid(res_valid), .pass(pass), .len_err(len_err),
    .crc_calc(crc_calc), .crc_rx(crc_rx), .blk_len(blk_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Counts result pulses and any s_ready drop outside a result cycle.
  always @(negedge clk) begin
    #1;
    if (res_valid === 1'b1) pulses++;
    if (s_ready === 1'b0 && res_valid !== 1'b1) bad_ready++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int w = 0;
    if (gaps) begin
      int g = $urandom_range(0, 3);
      if (g > 1) begin
        s_valid = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
    end
    s_data = d; s_last = l; s_valid = 1'b1;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("accept_timeout", 32'(s_ready), 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic send_block(input logic [7:0] q[$], input bit hold);
    foreach (q[i]) send_byte(q[i], i == q.size() - 1);
    if (!hold) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic check_res(input string t, input logic ep, input logic el,
                           input logic [23:0] ec, input logic [23:0] er, input logic [15:0] en);
    check({t, "_res_valid"}, 32'(res_valid), 32'd1);
    check({t, "_ready_done"}, 32'(s_ready), 32'd0);
    check({t, "_pass"}, 32'(pass), 32'(ep));
    check({t, "_len_err"}, 32'(len_err), 32'(el));
    check({t, "_crc_calc"}, 32'(crc_calc), 32'(ec));
    check({t, "_crc_rx"}, 32'(crc_rx), 32'(er));
    check({t, "_blk_len"}, 32'(blk_len), 32'(en));
  endtask

  logic [7:0] vec1[$] = '{8'h01, 8'h80, 8'h00, 8'h63};
  logic [7:0] vec2[$] = '{8'h01, 8'h80, 8'h00, 8'h62};
  logic [7:0] vec3[$] = '{8'h02, 8'h80, 8'h00, 8'hA5};
  logic [7:0] vshort[$] = '{8'hAA, 8'hBB, 8'hCC};
  logic [7:0] vzero[$];

  initial begin
    int p0;
    int ka;
    reset = 1'b1; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    check("rst_crc_calc", 32'(crc_calc), 32'd0);
    check("rst_crc_rx", 32'(crc_rx), 32'd0);
    check("rst_blk_len", 32'(blk_len), 32'd0);

    // Basic good block, then the strobe must drop after one cycle.
    send_block(vec1, 1'b0);
    check_res("v1", 1'b1, 1'b0, 24'h800063, 24'h800063, 16'd4);
    @(negedge clk);
    check("v1_strobe_one_cycle", 32'(res_valid), 32'd0);
    check("v1_ready_after", 32'(s_ready), 32'd1);

    send_block(vec2, 1'b0);
    check_res("v2", 1'b0, 1'b0, 24'h800063, 24'h800062, 16'd4);
    @(negedge clk);

    // Long all-zero block with random valid gaps.
    for (int i = 0; i < 771; i++) vzero.push_back(8'h00);
    gaps = 1'b1;
    send_block(vzero, 1'b0);
    gaps = 1'b0;
    check_res("zero", 1'b1, 1'b0, 24'h000000, 24'h000000, 16'd771);
    @(negedge clk);

    send_block(vshort, 1'b0);
    check_res("short", 1'b0, 1'b1, 24'h000000, 24'h000000, 16'd3);
    @(negedge clk);

    // Abort on byte 5 while valid is high.
    p0 = pulses;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    s_data = 8'h05; s_last = 1'b0; s_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    check("abort_no_strobe", 32'(res_valid), 32'd0);
    check("abort_blk_len_held", 32'(blk_len), 32'd3);
    check("abort_len_err_held", 32'(len_err), 32'd1);
    check("abort_s_ready", 32'(s_ready), 32'd1);
    send_block(vec1, 1'b0);
    check_res("post_abort", 1'b1, 1'b0, 24'h800063, 24'h800063, 16'd4);
    repeat (2) @(negedge clk);
    check("abort_pulse_count", 32'(pulses - p0), 32'd1);

    // Back-to-back blocks with valid held across DONE.
    send_block(vec1, 1'b1);
    ka = acc_cyc;
    check_res("b2b_a", 1'b1, 1'b0, 24'h800063, 24'h800063, 16'd4);
    send_byte(8'h02, 1'b0);
    check("b2b_first_byte_edge", 32'(acc_cyc - ka), 32'd2);
    send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA5, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    check_res("b2b_b", 1'b1, 1'b0, 24'h8000A5, 24'h8000A5, 16'd4);
    @(negedge clk);

    // Reset in the middle of a block.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_pass", 32'(pass), 32'd0);
    check("mid_rst_crc_calc", 32'(crc_calc), 32'd0);
    check("mid_rst_crc_rx", 32'(crc_rx), 32'd0);
    check("mid_rst_blk_len", 32'(blk_len), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    send_block(vec3, 1'b0);
    check_res("post_rst", 1'b1, 1'b0, 24'h8000A5, 24'h8000A5, 16'd4);
    repeat (2) @(negedge clk);

    check("ready_low_outside_done", 32'(bad_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc24_check.md
# crc24_check

Byte-serial CRC24 checker for the receive side of the code-block path. It accepts a block of payload bytes followed by three appended CRC bytes, MSB-first. It recomputes the CRC over the payload only and compares it against the received parity. It reports pass/fail, both CRC values and the block length in a one-cycle result strobe, then re-arms for the next block.

## Interface
- `POLY`, 24'h800063, generator polynomial without the x^24 term (CRC24B; 24'h864CFB gives CRC24A)
- `INIT`, 24'h000000, CRC register value at the start of each block
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- `abort`  in  1  synchronous block discard; returns the block to IDLE with no result
- `s_valid`  in  1  input byte valid
- `s_ready`  out  1  checker can accept a byte
- `s_data`  in  8  input byte; bit 7 is the first bit on the wire
- `s_last`  in  1  marks the final byte of the block (the last CRC byte)
- `res_valid`  out  1  one-cycle result strobe
- `pass`  out  1  crc_calc == crc_rx and no length error
- `len_err`  out  1  block shorter than 4 bytes
- `crc_calc`  out  24  CRC computed over the payload
- `crc_rx`  out  24  received CRC; first CRC byte in bits 23:16
- `blk_len`  out  16  total bytes in the block including CRC; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, RUN, DONE.
  - `s_ready` = 1 in IDLE and RUN, 0 in DONE.
  - A beat is accepted when `s_valid & s_ready`.
- IDLE:
  - The CRC register holds INIT, the delay line is empty and the counter is 0.
  - An accepted beat without `s_last` goes to RUN.
  - An accepted beat with `s_last` goes to DONE.
- RUN:
  - Each accepted beat shifts `s_data` into a 3-deep byte delay line (dl0 newest, dl2 oldest) and increments the counter.
  - Once the line is full (counter ≥ 3 before the beat), the byte leaving dl2 is folded into the CRC register: 8 MSB-first bit steps per cycle using POLY, no reflection, no final XOR.
  - An accepted beat with `s_last` goes to DONE.
- Result capture on the `s_last` beat, counting that beat as byte n:
  - `crc_rx` = {dl1, dl0, s_data}.
  - `crc_calc` = CRC register after folding dl2 in that same cycle.
  - `blk_len` = n.
  - `len_err` = (n < 4).
  - `pass` = !len_err & (crc_calc == crc_rx).
  - When `len_err` = 1, `crc_calc` = 0 and `crc_rx` = 0.
- DONE:
  - Lasts exactly one cycle with `res_valid` = 1, then returns to IDLE.
  - Re-initialises the CRC register, the delay line and the counter.
- Result fields hold their value until the next result capture.
- `abort` (any state) → IDLE on the next edge:
  - The partial block is discarded and no `res_valid` is produced.
  - Result fields are unchanged.
  - `abort` together with an accepted beat: `abort` wins and the byte is dropped.
- `reset` mid-block: same as `abort`, and additionally every output register is cleared.
- Reset values:
  - `res_valid`, `pass`, `len_err`: 0.
  - `crc_calc`, `crc_rx`: 0.
  - `blk_len`: 0.
  - State: IDLE, so `s_ready` = 1.
- The block ignores `s_data` and `s_last` when `s_valid` = 0.

## Timing
- `s_ready` is a combinational decode of the FSM state; it never depends combinationally on `s_valid`.
- Throughput: one byte per cycle in RUN.
  - One bubble per block: `s_ready` = 0 during the DONE cycle.
- Latency: `s_last` accepted at edge k → `res_valid` = 1 and all result fields valid during cycle k+1 → next block's first byte accepted at edge k+2 at the earliest.
- Input stalls (`s_valid` = 0) in RUN hold all state; a gap of any length is legal.
- The CRC fold is a single-cycle combinational 8-step unroll derived from POLY; there is no multicycle path.

## Test plan
- Payload 0x01 plus CRC 0x80 0x00 0x63, continuous valid → one `res_valid` pulse with `pass` = 1, `crc_calc` = 0x800063, `crc_rx` = 0x800063, `blk_len` = 4, `len_err` = 0.
- Same block with last byte 0x62 → `pass` = 0, `crc_rx` = 0x800062, `crc_calc` = 0x800063.
- 768 zero payload bytes plus 0x00 0x00 0x00, with random `s_valid` gaps → `pass` = 1, `crc_calc` = 0, `blk_len` = 771; `s_ready` low only in the DONE cycle.
- Three-byte block 0xAA 0xBB 0xCC with `s_last` on the third byte → `len_err` = 1, `pass` = 0, `crc_calc` = 0, `crc_rx` = 0, `blk_len` = 3.
- Start a block, assert `abort` on byte 5 with `s_valid` = 1, then send the first test vector → no `res_valid` for the aborted block; the next result matches the first test vector exactly.
- Back-to-back blocks with `s_valid` held high across DONE → the byte presented during DONE is not accepted and is held; it is accepted at edge k+2 as the first byte of the second block; both results are correct.
- `reset` pulsed mid-block → all outputs 0 on the next cycle, `s_ready` = 1, and the following block is checked correctly.
